// File: rtl/store_ctrl.sv
// ---------------------------------------------------------------------------
// store_ctrl
//   MEM-stage store sequencer. Accepts one store request (type, address,
//   data) while idle, computes byte lanes and lane-aligned write data, and
//   issues one or two word-aligned write beats over a req/ack handshake.
//   The pipeline is held (st_ready=0) until the store retires.
//
//   Handshake: a store is accepted on a rising edge where st_ready=1 and
//   st_valid=1. A beat is transferred on a rising edge where mem_req=1 and
//   mem_ack=1; mem_addr/mem_be/mem_wdata are held stable until then and
//   mem_ack is ignored while mem_req=0.
//
//   Optional feature macro: STORE_MISALIGN_TRAP_EN
//     defined   - misaligned half/word stores are not issued; the FSM spends
//                 one cycle in TRAP and retires with st_done+st_err.
//     undefined - misaligned stores are split into two beats.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   st_valid   in   1   store request valid
//   st_type    in   2   00 word, 01 byte, 10 half, 11 word
//   st_addr    in   32  byte address
//   st_data    in   32  store data, LSB-justified
//   st_ready   out  1   idle, request can be accepted
//   st_done    out  1   one-cycle pulse: store retired
//   st_err     out  1   one-cycle pulse with st_done: store aborted
//   mem_req    out  1   write beat request
//   mem_addr   out  32  word-aligned beat address
//   mem_wdata  out  32  lane-aligned write data (disabled lanes zero)
//   mem_be     out  4   byte enables
//   mem_ack    in   1   beat accepted
// ---------------------------------------------------------------------------
module store_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        st_done,
    output logic        st_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2
`ifdef STORE_MISALIGN_TRAP_EN
        ,
        S_TRAP  = 2'd3
`endif
    } state_e;

    // The timeout fires on the edge that would take the counter to
    // MEM_TIMEOUT, so mem_req is high for exactly MEM_TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    // Upper half of the 64-bit lane window, replayed as beat1 when non-zero.
    logic [31:0] hi_wdata_q, hi_wdata_d;
    logic [3:0]  hi_be_q, hi_be_d;

    logic [3:0]  lane_mask;
    logic [31:0] lane_data;
    logic [7:0]  be64;
    logic [63:0] wd64;

    always_comb begin
        lane_mask = 4'b1111;
        lane_data = st_data;
        case (st_type)
            2'b01: begin
                lane_mask = 4'b0001;
                lane_data = {24'b0, st_data[7:0]};
            end
            2'b10: begin
                lane_mask = 4'b0011;
                lane_data = {16'b0, st_data[15:0]};
            end
            default: ;
        endcase
        be64 = {4'b0000, lane_mask} << st_addr[1:0];
        wd64 = {32'b0, lane_data} << {st_addr[1:0], 3'b000};
    end

`ifdef STORE_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((st_type == 2'b10) && st_addr[0]) ||
                        ((st_type != 2'b01) && (st_type != 2'b10) &&
                         (st_addr[1:0] != 2'b00));
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        hi_wdata_d = hi_wdata_q;
        hi_be_d    = hi_be_q;
        case (state_q)
            S_IDLE: begin
                if (st_valid) begin
                    state_d    = S_BEAT0;
                    cnt_d      = 8'd0;
                    addr_d     = {st_addr[31:2], 2'b00};
                    be_d       = be64[3:0];
                    wdata_d    = wd64[31:0];
                    hi_be_d    = be64[7:4];
                    hi_wdata_d = wd64[63:32];
`ifdef STORE_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d = S_TRAP;
                    end
`endif
                end
            end
            S_BEAT0, S_BEAT1: begin
                // An ack on the limit cycle wins over the timeout.
                if (mem_ack) begin
                    if ((state_q == S_BEAT0) && (hi_be_q != 4'b0000)) begin
                        state_d = S_BEAT1;
                        cnt_d   = 8'd0;
                        addr_d  = addr_q + 32'd4; // wraps past 0xFFFFFFFC
                        be_d    = hi_be_q;
                        wdata_d = hi_wdata_q;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef STORE_MISALIGN_TRAP_EN
            S_TRAP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            hi_wdata_q <= 32'd0;
            hi_be_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            hi_wdata_q <= hi_wdata_d;
            hi_be_q    <= hi_be_d;
        end
    end

    assign st_ready  = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    assign st_done   = done_q;
    assign st_err    = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule

// File: tb/tb_store_ctrl.sv
// ---------------------------------------------------------------------------
// tb_store_ctrl
//   Bench for store_ctrl. Expected beats are built byte by byte from the
//   store's byte addresses (each byte lands in word addr&~3, lane addr&3),
//   and expected latency/error come from the per-beat ack delays.
// ---------------------------------------------------------------------------
module tb_store_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_done;
    logic        st_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    int n_checks;
    int n_fails;

    // {addr[31:0], be[3:0], wdata[31:0]}
    logic [67:0] exp_q[$];

    store_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_type   (st_type),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .st_done   (st_done),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_trap(input logic [1:0] t, input logic [31:0] a);
`ifdef STORE_MISALIGN_TRAP_EN
        if (t == 2'b10) return a[0];
        if (t != 2'b01) return (a[1:0] != 2'b00);
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // Fills exp_q with the beats that will actually be issued and returns
    // the expected accept-to-done latency, error flag and mem_req cycles.
    task automatic build_model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                               input int d0, input int d1,
                               output int lat, output bit err, output int req_cyc);
        logic [67:0] beats[$];
        logic [31:0] ba, w;
        logic [3:0]  be;
        logic [31:0] wd;
        int          nbytes;
        int          dly;
        nbytes = (t == 2'b01) ? 1 : (t == 2'b10) ? 2 : 4;
        exp_q.delete();
        lat = 1;
        err = 1'b0;
        req_cyc = 0;
        if (is_trap(t, a)) begin
            lat = 2;
            err = 1'b1;
            return;
        end
        w  = {a[31:2], 2'b00};
        be = 4'b0;
        wd = 32'b0;
        for (int i = 0; i < nbytes; i++) begin
            ba = a + 32'(i);
            if ({ba[31:2], 2'b00} != w) begin
                beats.push_back({w, be, wd});
                w  = {ba[31:2], 2'b00};
                be = 4'b0;
                wd = 32'b0;
            end
            be[ba[1:0]] = 1'b1;
            wd[ba[1:0]*8 +: 8] = d[i*8 +: 8];
        end
        beats.push_back({w, be, wd});
        for (int b = 0; b < beats.size(); b++) begin
            dly = (b == 0) ? d0 : d1;
            exp_q.push_back(beats[b]);
            if (dly >= TO) begin
                lat += TO;
                req_cyc += TO;
                err = 1'b1;
                break;
            end
            lat += dly + 1;
            req_cyc += dly + 1;
        end
    endtask

    // ---------------- driver + scoreboard ----------------
    // Called at a negedge with the DUT idle; returns at the negedge where
    // st_done is observed, so the next call is accepted back-to-back.
    task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                            input int d0, input int d1);
        int          exp_lat, exp_req_cyc, cyc, rc, bi, req_seen, dly;
        bit          exp_err, done_seen, exp_req;
        logic [67:0] cur;
        build_model(t, a, d, d0, d1, exp_lat, exp_err, exp_req_cyc);
        exp_req = !is_trap(t, a);
        check("ready_before", 32'(st_ready), 32'd1);
        st_valid = 1'b1;
        st_type  = t;
        st_addr  = a;
        st_data  = d;
        mem_ack  = 1'b0;
        cyc = 0; rc = 0; bi = 0; req_seen = 0; done_seen = 1'b0; cur = '0;
        for (int k = 0; k < 40 && !done_seen; k++) begin
            @(negedge clk);
            cyc++;
            // Junk requests while busy must be ignored.
            st_valid = 1'($urandom_range(0, 1));
            st_type  = 2'($urandom_range(0, 3));
            st_addr  = $urandom;
            st_data  = $urandom;
            if (st_done) begin
                done_seen = 1'b1;
                st_valid  = 1'b0;
                mem_ack   = 1'b0;
                check("latency", 32'(cyc), 32'(exp_lat));
                check("st_err", 32'(st_err), 32'(exp_err));
                check("ready_at_done", 32'(st_ready), 32'd1);
                check("req_at_done", 32'(mem_req), 32'd0);
                check("beats_left", 32'(exp_q.size()), 32'd0);
                check("req_cycles", 32'(req_seen), 32'(exp_req_cyc));
            end else begin
                check("mem_req", 32'(mem_req), 32'(exp_req));
                check("err_early", 32'(st_err), 32'd0);
                mem_ack = 1'b0;
                if (mem_req) begin
                    if (rc == 0) begin
                        if (exp_q.size() > 0) cur = exp_q.pop_front();
                        else begin
                            check("extra_beat", 32'd1, 32'd0);
                            cur = '0;
                        end
                    end
                    check("mem_addr", mem_addr, cur[67:36]);
                    check("mem_be", 32'(mem_be), 32'(cur[35:32]));
                    check("mem_wdata", mem_wdata, cur[31:0]);
                    req_seen++;
                    rc++;
                    dly = (bi == 0) ? d0 : d1;
                    mem_ack = (rc > dly);
                    if (mem_ack || rc == TO) begin
                        bi++;
                        rc = 0;
                    end
                end
            end
        end
        if (!done_seen) begin
            check("done_budget", 32'd0, 32'd1);
            st_valid = 1'b0;
            mem_ack  = 1'b0;
        end
    endtask

    // Reset asserted while a store is in flight.
    task automatic reset_mid_op();
        logic [31:0] a, exp_a;
        bit          split;
`ifdef STORE_MISALIGN_TRAP_EN
        a = 32'h300; split = 1'b0; exp_a = 32'h300;
`else
        a = 32'h301; split = 1'b1; exp_a = 32'h304;
`endif
        st_valid = 1'b1; st_type = 2'b00; st_addr = a; st_data = 32'hDDCCBBAA;
        @(negedge clk);                  // BEAT0
        st_valid = 1'b0;
        mem_ack  = split;
        @(negedge clk);                  // BEAT1 (or still BEAT0)
        check("rst_req_busy", 32'(mem_req), 32'd1);
        check("rst_addr_busy", mem_addr, exp_a);
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_ready", 32'(st_ready), 32'd1);
        check("rst_done", 32'(st_done), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_done", 32'(st_done), 32'd0);
        check("rst_ready2", 32'(st_ready), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_type  = 2'b00;
        st_addr  = 32'd0;
        st_data  = 32'd0;
        mem_ack  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(st_ready), 32'd1);
        check("reset_done", 32'(st_done), 32'd0);
        check("reset_err", 32'(st_err), 32'd0);
        check("reset_req", 32'(mem_req), 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        check("reset_be", 32'(mem_be), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_store(2'b01, 32'h0000_0103, 32'h0000_00AB, 0, 0);  // byte, lane 3
        do_store(2'b10, 32'h0000_0202, 32'h1234_BEEF, 0, 0);  // half, upper
        do_store(2'b00, 32'h0000_0301, 32'hDDCC_BBAA, 0, 0);  // word split / trap
        do_store(2'b00, 32'h0000_0400, 32'h1111_2222, 9, 0);  // timeout
        do_store(2'b00, 32'h0000_0400, 32'h3333_4444, 3, 0);  // ack on limit cycle
        do_store(2'b00, 32'h0000_0502, 32'h5566_7788, 0, 9);  // beat1 timeout
        do_store(2'b00, 32'hFFFF_FFFE, 32'h1122_3344, 0, 0);  // wrap
        do_store(2'b11, 32'h0000_0600, 32'hCAFE_F00D, 1, 0);  // type 11 as word
        do_store(2'b10, 32'h0000_0703, 32'hAAAA_5A5A, 2, 2);  // half split
        @(negedge clk);
        reset_mid_op();
        do_store(2'b00, 32'h0000_0800, 32'h0BAD_F00D, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                2: a = 32'($urandom_range(0, 64));
                default: a = {$urandom_range(0, 255), 2'b00} + 32'($urandom_range(0, 3));
            endcase
            do_store(2'($urandom_range(0, 3)), a, $urandom,
                     $urandom_range(0, 5), $urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/store_ctrl.md
Name: store_ctrl

Overview:
- Sequences the MEM-stage store path between the pipeline and data memory.
- Accepts one store request (type, address, data) from EXE/MEM and computes byte lanes and aligned write data.
- Issues one or two word-aligned write beats over a req/ack memory handshake and holds the pipeline via st_ready until the store retires.
- Store type encoding matches the store extender: 2'b00 word, 2'b01 byte, 2'b10 half, 2'b11 treated as word.

Parameters:
- MEM_TIMEOUT, 255: cycles mem_req may stay high without mem_ack before the beat is aborted (8-bit counter, range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- st_valid  in  1  store request valid.
- st_type  in  2  00 word, 01 byte, 10 half, 11 word.
- st_addr  in  32  byte address.
- st_data  in  32  store data, LSB-justified.
- st_ready  out  1  controller idle, can accept a request; pipeline stalls while low.
- st_done  out  1  one-cycle pulse: store retired (normally or on error).
- st_err  out  1  one-cycle pulse with st_done: store aborted.
- mem_req  out  1  write beat request.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  beat accepted; sampled only while mem_req=1.

Behaviour:
- Reset values (next edge with rst_n=0): state IDLE, st_ready=1, st_done=0, st_err=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, timeout counter=0.
- Reset asserted mid-transaction: abandon the beat, return to IDLE, deassert mem_req next edge, no st_done.
- States: IDLE, BEAT0, BEAT1.
- IDLE:
  - st_ready=1.
  - st_valid=1 latches type/addr/data and goes to BEAT0.
  - st_valid is ignored in any state other than IDLE.
- Lane computation, with k=addr[1:0]:
  - Mask: byte 4'b0001, half 4'b0011, word 4'b1111. Data: byte {24'b0,d[7:0]}, half {16'b0,d[15:0]}, word d.
  - be64 = {4'b0,mask}<<k; wd64 = {32'b0,data}<<(8k).
  - Beat0 uses be64[3:0] and wd64[31:0] at addr word.
  - Beat1 is needed iff be64[7:4]!=0; it uses be64[7:4] and wd64[63:32] at addr word+4, with wrap at 0xFFFFFFFC to 0x00000000.
  - Only enabled lanes carry meaningful data. Disabled lanes must be 0.
- BEAT0:
  - mem_req=1; mem_addr/mem_be/mem_wdata stable until ack.
  - On mem_ack: go to BEAT1 if split, else go to IDLE and assert st_done.
  - mem_req is not dropped between beat0 and beat1 if beat1 follows.
- BEAT1: same as BEAT0. On mem_ack go to IDLE and assert st_done.
- Timeout:
  - Counter clears at each beat start and increments each cycle with mem_req=1 and mem_ack=0.
  - When it reaches MEM_TIMEOUT: drop mem_req, go to IDLE, pulse st_done and st_err.
  - A split store that times out on beat1 has already written beat0. No rollback.
  - mem_ack in the same cycle the counter hits the limit takes priority: beat succeeds.
- Timing:
  - st_done/st_err are registered and assert in the first IDLE cycle after retirement.
  - st_ready is also 1 in that cycle, so a new request may be accepted the same cycle st_done pulses.
- Latency (accept edge to st_done), with mem_ack asserted on the first mem_req cycle:
  - Aligned store: 2 cycles.
  - Split store: 3 cycles.

Optional Feature:
- STORE_MISALIGN_TRAP_EN.
- Defined:
  - Half stores with k odd and word stores with k!=0 are never issued: no mem_req.
  - The controller goes from IDLE to a TRAP state for one cycle, then returns to IDLE pulsing st_done and st_err.
  - The BEAT1 state and wrap logic may be omitted.
- Undefined: misaligned stores are split as described above; TRAP state does not exist.

Test Plan:
- Byte store: st_type=01, addr=0x103, data=0xAB, mem_ack tied 1 -> one beat: mem_addr=0x100, be=1000, wdata=0xAB000000; st_done 2 cycles after accept; st_err=0.
- Half aligned: type=10, addr=0x202, data=0x1234BEEF -> one beat: be=1100, wdata=0xBEEF0000, addr=0x200.
- Word split: type=00, addr=0x301, data=0xDDCCBBAA (trap macro off) -> beat0 addr=0x300, be=1110, wdata=0xCCBBAA00; beat1 addr=0x304, be=0001, wdata=0x000000DD; mem_req continuous; st_done 3 cycles after accept.
- Backpressure and timeout: MEM_TIMEOUT=4, mem_ack held 0 -> mem_req high exactly 4 cycles, then st_done=st_err=1 for one cycle, st_ready=1. Repeat with ack on cycle 4 -> success, st_err=0.
- Reset mid-op: assert rst_n=0 during BEAT1 of a split store -> next edge mem_req=0, st_ready=1, no st_done; a fresh aligned store afterwards completes normally.
- Wrap and trap: type=00, addr=0xFFFFFFFE -> beat1 mem_addr=0x00000000, be=0011. With STORE_MISALIGN_TRAP_EN defined -> no mem_req, st_done and st_err pulse 2 cycles after accept.
